// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types for the mips_mem_arbiter slice: arbiter FSM states and
// SRAM port grant codes.
package mips_mem_arbiter_pkg;

  typedef enum logic {
    ARB_FETCH  = 1'b0,
    ARB_DSTALL = 1'b1
  } arb_state_t;

  typedef enum logic {
    GNT_INS  = 1'b0,
    GNT_DATA = 1'b1
  } arb_gnt_t;

endpackage

// File: rtl/mips_mem_arbiter_hold.sv
// arb_hold_reg: 32-bit mux + hold register. Passes live SRAM data when this
// consumer owns the previous cycle's grant, otherwise replays the last value.
module arb_hold_reg #(
  parameter logic [31:0] RST_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [31:0] din,
  output logic [31:0] q
);

  logic [31:0] hold;

  // Output: reset value during reset, live data when selected, else held value
  always_comb begin
    q = hold;
    if (!rst)
      q = RST_VAL;
    else if (sel)
      q = din;
  end

  // Capture whatever is presented so it survives the next non-selected cycle
  always_ff @(posedge clk) begin
    if (!rst)
      hold <= RST_VAL;
    else
      hold <= q;
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port synchronous SRAM between the
// mips_core fetch port and data port. Data wins; the core is paused for one
// cycle per data access and the following cycle is always given back to fetch.
// Optional build macro MEM_ARB_PERF_EN adds stall_cnt_o (saturating count of
// cycles with pause_o=1).
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] RST_INS = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_addr_i,
  output logic [31:0]       ins_o,
  input  logic [31:0]       d_addr_i,
  input  logic              d_rd_i,
  input  logic [3:0]        d_wr_en_i,
  input  logic [31:0]       d_dout_i,
  output logic [31:0]       d_din_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_wr_en_o,
  output logic [31:0]       mem_dout_o,
  input  logic [31:0]       mem_din_i,
  output logic              pause_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  arb_state_t state;
  arb_gnt_t   g_q;
  logic       d_req;
  logic       data_sel;
  logic       unused_addr_bits;

  assign d_req = d_rd_i | (|d_wr_en_i);

  // Upper and byte-offset address bits do not reach the SRAM (wrap-around)
  assign unused_addr_bits = ^{i_addr_i[31:ADDR_W+2], i_addr_i[1:0],
                              d_addr_i[31:ADDR_W+2], d_addr_i[1:0]};

  // Arbiter FSM: a data request in FETCH takes the port for one cycle, then
  // DSTALL unconditionally returns it to fetch so instructions never starve
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ARB_FETCH;
      g_q   <= GNT_INS;
    end else begin
      case (state)
        ARB_FETCH: begin
          if (d_req) begin
            state <= ARB_DSTALL;
            g_q   <= GNT_DATA;
          end else begin
            state <= ARB_FETCH;
            g_q   <= GNT_INS;
          end
        end
        default: begin
          state <= ARB_FETCH;
          g_q   <= GNT_INS;
        end
      endcase
    end
  end

  // SRAM port mux and stall; reset forces the instruction side with no write
  always_comb begin
    data_sel    = rst && (state == ARB_FETCH) && d_req;
    pause_o     = data_sel;
    mem_addr_o  = data_sel ? d_addr_i[ADDR_W+1:2] : i_addr_i[ADDR_W+1:2];
    mem_wr_en_o = data_sel ? d_wr_en_i : '0;
    mem_dout_o  = data_sel ? d_dout_i : '0;
  end

  arb_hold_reg #(.RST_VAL(RST_INS)) u_ins_hold (
    .clk (clk),
    .rst (rst),
    .sel (g_q == GNT_INS),
    .din (mem_din_i),
    .q   (ins_o)
  );

  arb_hold_reg #(.RST_VAL(32'h0)) u_data_hold (
    .clk (clk),
    .rst (rst),
    .sel (g_q == GNT_DATA),
    .din (mem_din_i),
    .q   (d_din_o)
  );

`ifdef MEM_ARB_PERF_EN
  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt_o <= '0;
    else if (pause_o && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a behavioural synchronous SRAM
// (read returns old data on a same-cycle write).
module tb_mips_mem_arbiter;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       i_addr_i;
  logic [31:0]       ins_o;
  logic [31:0]       d_addr_i;
  logic              d_rd_i;
  logic [3:0]        d_wr_en_i;
  logic [31:0]       d_dout_i;
  logic [31:0]       d_din_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_wr_en_o;
  logic [31:0]       mem_dout_o;
  logic [31:0]       mem_din_i;
  logic              pause_o;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       stall_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] ram [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  mips_mem_arbiter #(.ADDR_W(ADDR_W), .RST_INS(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_addr_i    (i_addr_i),
    .ins_o       (ins_o),
    .d_addr_i    (d_addr_i),
    .d_rd_i      (d_rd_i),
    .d_wr_en_i   (d_wr_en_i),
    .d_dout_i    (d_dout_i),
    .d_din_o     (d_din_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wr_en_o (mem_wr_en_o),
    .mem_dout_o  (mem_dout_o),
    .mem_din_i   (mem_din_i),
    .pause_o     (pause_o)
`ifdef MEM_ARB_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  // Synchronous SRAM model with byte enables
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wr_en_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_dout_o[8*b +: 8];
    mem_din_i <= ram[mem_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: leave the current cycle, drive next inputs at #1
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'h1000_0000 + i;
    mem_din_i = '0;

    // Test 1: reset held 3 cycles with spurious write enables
    rst = 1'b0; i_addr_i = 32'h0; d_addr_i = 32'h40; d_rd_i = 1'b0;
    d_wr_en_i = 4'hF; d_dout_i = 32'h1234_5678;
    #1;
    for (int c = 0; c < 3; c++) begin
      sample;
      check("rst_wr_en", {28'h0, mem_wr_en_o}, 32'h0);
      check("rst_pause", {31'h0, pause_o}, 32'h0);
      check("rst_ins", ins_o, 32'h0);
      check("rst_ddin", d_din_o, 32'h0);
      next_cycle;
    end
    check("rst_no_write", ram[16], 32'h1000_0010);

    // Test 2: fetch only, pc 0,4,8,12
    rst = 1'b1; d_wr_en_i = 4'h0; i_addr_i = 32'h0;
    sample;
    check("f0_addr", {20'h0, mem_addr_o}, 32'h0);
    check("f0_pause", {31'h0, pause_o}, 32'h0);
    next_cycle; i_addr_i = 32'h4;
    sample;
    check("f1_addr", {20'h0, mem_addr_o}, 32'h1);
    check("f1_ins", ins_o, 32'h1000_0000);
    next_cycle; i_addr_i = 32'h8;
    sample;
    check("f2_addr", {20'h0, mem_addr_o}, 32'h2);
    check("f2_ins", ins_o, 32'h1000_0001);
    next_cycle; i_addr_i = 32'hC;
    sample;
    check("f3_ins", ins_o, 32'h1000_0002);
    check("f3_pause", {31'h0, pause_o}, 32'h0);

    // Test 3: word write 0xDEADBEEF to 0x40 while pc=16
    next_cycle; i_addr_i = 32'h10; d_addr_i = 32'h40; d_wr_en_i = 4'hF; d_dout_i = 32'hDEAD_BEEF;
    sample;
    check("w_pause", {31'h0, pause_o}, 32'h1);
    check("w_addr", {20'h0, mem_addr_o}, 32'h10);
    check("w_wr_en", {28'h0, mem_wr_en_o}, 32'hF);
    check("w_dout", mem_dout_o, 32'hDEAD_BEEF);
    check("w_ins", ins_o, 32'h1000_0003);
    next_cycle;  // core stalled: all requests held
    sample;
    check("ws_pause", {31'h0, pause_o}, 32'h0);
    check("ws_addr", {20'h0, mem_addr_o}, 32'h4);
    check("ws_wr_en", {28'h0, mem_wr_en_o}, 32'h0);
    check("ws_ins_hold", ins_o, 32'h1000_0003);
    next_cycle; d_wr_en_i = 4'h0; i_addr_i = 32'h14;
    sample;
    check("w_ram", ram[16], 32'hDEAD_BEEF);
    check("wr_ins", ins_o, 32'h1000_0004);
    check("wr_addr", {20'h0, mem_addr_o}, 32'h5);

    // Test 4: read back through a wrapped address (upper bits ignored)
    next_cycle; i_addr_i = 32'h18; d_addr_i = 32'hFFFF_C040; d_rd_i = 1'b1;
    sample;
    check("r_pause", {31'h0, pause_o}, 32'h1);
    check("r_addr_wrap", {20'h0, mem_addr_o}, 32'h10);
    check("r_wr_en", {28'h0, mem_wr_en_o}, 32'h0);
    check("r_ins", ins_o, 32'h1000_0005);
    next_cycle;
    sample;
    check("r_ddin", d_din_o, 32'hDEAD_BEEF);
    check("r_ins_hold", ins_o, 32'h1000_0005);
    check("r_stall_pause", {31'h0, pause_o}, 32'h0);
    check("r_stall_addr", {20'h0, mem_addr_o}, 32'h6);
    next_cycle; d_rd_i = 1'b0; i_addr_i = 32'h1C;
    sample;
    check("r_ddin_hold", d_din_o, 32'hDEAD_BEEF);
    check("r_ins_next", ins_o, 32'h1000_0006);

    // Test 5: d_rd_i held 6 cycles -> pause 1,0,1,0,1,0
    next_cycle; d_rd_i = 1'b1; d_addr_i = 32'h44;
    sample; check("b2b_p0", {31'h0, pause_o}, 32'h1);
    check("b2b_a0", {20'h0, mem_addr_o}, 32'h11);
    next_cycle; sample; check("b2b_p1", {31'h0, pause_o}, 32'h0);
    check("b2b_a1", {20'h0, mem_addr_o}, 32'h7);
    check("b2b_ddin", d_din_o, 32'h1000_0011);
    next_cycle; sample; check("b2b_p2", {31'h0, pause_o}, 32'h1);
    check("b2b_ins", ins_o, 32'h1000_0007);
    next_cycle; sample; check("b2b_p3", {31'h0, pause_o}, 32'h0);
    next_cycle; sample; check("b2b_p4", {31'h0, pause_o}, 32'h1);
    next_cycle; sample; check("b2b_p5", {31'h0, pause_o}, 32'h0);

    // Test 6: enter DSTALL, then reset there with a spurious write request
    next_cycle;
    sample; check("pre_rst_pause", {31'h0, pause_o}, 32'h1);
`ifdef MEM_ARB_PERF_EN
    check("stall_cnt", stall_cnt_o, 32'd5);
`endif
    next_cycle; rst = 1'b0; d_rd_i = 1'b0; d_wr_en_i = 4'hF; d_addr_i = 32'h40; d_dout_i = 32'h1234_5678;
    sample;
    check("ds_rst_pause", {31'h0, pause_o}, 32'h0);
    check("ds_rst_wr_en", {28'h0, mem_wr_en_o}, 32'h0);
    check("ds_rst_ins", ins_o, 32'h0);
    check("ds_rst_ddin", d_din_o, 32'h0);
    next_cycle; rst = 1'b1; d_wr_en_i = 4'h0;
    sample;
    check("post_rst_pause", {31'h0, pause_o}, 32'h0);
    check("post_rst_addr", {20'h0, mem_addr_o}, 32'h7);
    check("post_rst_ins", ins_o, 32'h1000_0007);
    check("post_rst_ram", ram[16], 32'hDEAD_BEEF);
`ifdef MEM_ARB_PERF_EN
    check("stall_cnt_rst", stall_cnt_o, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
